spi_master: RTL

//   Byte-oriented SPI mode-0 master; the initiator end of spi_slave's link. On start it

---
 rtl/spi_master_if.sv | 34 +++
 rtl/spi_master.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - host, memory and SPI pin bundle for spi_master
// Purpose: groups the transaction handshake, local memory port and SPI pins.
// Ports (master view):
//   in : start, op, cmd[COMMAND_SIZE], size, data_in, miso
//   out: address, data_out, wr, busy, done, sclk, mosi, cs_n
interface spi_master_if #(
  parameter int COMMAND_SIZE = 6,
  parameter int AW           = 6
);
  logic          start;
  logic          op;
  logic [7:0]    cmd [COMMAND_SIZE];
  logic [AW-1:0] size;
  logic [7:0]    data_in;
  logic [AW-1:0] address;
  logic [7:0]    data_out;
  logic          wr;
  logic          busy;
  logic          done;
  logic          sclk;
  logic          mosi;
  logic          miso;
  logic          cs_n;

  modport master (
    input  start, op, cmd, size, data_in, miso,
    output address, data_out, wr, busy, done, sclk, mosi, cs_n
  );

  modport slave (
    output start, op, cmd, size, data_in, miso,
    input  address, data_out, wr, busy, done, sclk, mosi, cs_n
  );
endinterface

// File: rtl/spi_master.sv
// rtl/spi_master.sv - byte-oriented SPI mode-0 master: command, gap, then TX or RX data
// Purpose: on start, asserts cs_n, shifts out COMMAND_SIZE command bytes MSB first,
//   idles GAP_BITS sclk periods, then streams size+1 bytes from memory (op=1) or
//   captures size+1 bytes from miso into memory (op=0). All outputs are registered.
// Ports: clk, rst (sync active-high), bus (spi_master_if.master):
//   start/op/cmd/size latched in IDLE; busy/done status; address/data_in/data_out/wr
//   memory port; sclk/mosi/miso/cs_n SPI pins.
module spi_master #(
  parameter int COMMAND_SIZE         = 6,
  parameter int MEMORY_SIZE_IN_BYTES = 64,
  parameter int CLK_DIV              = 4,
  parameter int GAP_BITS             = 8,
  localparam int AW                  = $clog2(MEMORY_SIZE_IN_BYTES)
) (
  input logic          clk,
  input logic          rst,
  spi_master_if.master bus
);
  localparam int AW1   = AW + 1;
  localparam int DW    = $clog2(CLK_DIV);
  localparam int GW    = (GAP_BITS > 1) ? $clog2(2 * GAP_BITS) : 1;
  localparam int CMD_W = 8 * COMMAND_SIZE;

  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'(2 * GAP_BITS - 1);
  localparam logic [AW1-1:0] CMD_LAST = AW1'(COMMAND_SIZE - 1);

  typedef enum logic [2:0] {IDLE, CMD, GAP, TX, RX} state_t;

  state_t         state;
  logic [DW-1:0]  div;
  logic [2:0]     bit_cnt;
  logic [AW1-1:0] byte_cnt;   // one bit wider so size = max never wraps
  logic [GW-1:0]  gap_cnt;    // counts gap half-periods
  logic [CMD_W-1:0] cmd_sr;   // cmd[0] in the top byte
  logic [7:0]     shreg;
  logic           op_q;
  logic [AW-1:0]  size_q;

  logic tick;
  logic last_byte;
  logic finish;

  assign tick      = (div == DIV_LAST);
  assign last_byte = (byte_cnt == {1'b0, size_q});
  // Final sclk fall of the last data byte ends the transaction.
  assign finish    = tick && bus.sclk && (bit_cnt == 3'd7) && last_byte &&
                     (state == TX || state == RX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      div          <= '0;
      bit_cnt      <= '0;
      byte_cnt     <= '0;
      gap_cnt      <= '0;
      cmd_sr       <= '0;
      shreg        <= '0;
      op_q         <= 1'b0;
      size_q       <= '0;
      bus.sclk     <= 1'b0;
      bus.mosi     <= 1'b1;
      bus.cs_n     <= 1'b1;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.wr       <= 1'b0;
      bus.address  <= '0;
      bus.data_out <= '0;
    end else begin
      bus.done <= 1'b0;
      bus.wr   <= 1'b0;
      div      <= (state == IDLE || tick) ? '0 : div + 1'b1;

      case (state)
        IDLE: begin
          if (bus.start) begin
            for (int j = 0; j < COMMAND_SIZE; j++) begin
              cmd_sr[CMD_W-8-8*j +: 8] <= bus.cmd[j];
            end
            op_q        <= bus.op;
            size_q      <= bus.size;
            bus.cs_n    <= 1'b0;
            bus.busy    <= 1'b1;
            bus.mosi    <= bus.cmd[0][7];
            bus.address <= '0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            state       <= CMD;
          end
        end

        CMD: begin
          if (tick) begin
            bus.sclk <= ~bus.sclk;
            if (bus.sclk) begin
              if (bit_cnt == 3'd7 && byte_cnt == CMD_LAST) begin
                state    <= GAP;
                bus.mosi <= 1'b1;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                gap_cnt  <= '0;
              end else begin
                cmd_sr   <= cmd_sr << 1;
                bus.mosi <= cmd_sr[CMD_W-2];
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) byte_cnt <= byte_cnt + 1'b1;
              end
            end
          end
        end

        GAP: begin
          if (tick) begin
            if (gap_cnt == GAP_LAST) begin
              bit_cnt  <= '0;
              byte_cnt <= '0;
              if (op_q) begin
                // address is still 0 here, so data_in already holds byte 0
                state    <= TX;
                shreg    <= bus.data_in;
                bus.mosi <= bus.data_in[7];
              end else begin
                state <= RX;
              end
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end

        TX: begin
          if (tick) begin
            bus.sclk <= ~bus.sclk;
            if (!bus.sclk) begin
              // Prefetch the next byte early; it is consumed at this byte's last fall.
              if (bit_cnt == 3'd0) begin
                bus.address <= last_byte ? size_q : AW'(byte_cnt + 1'b1);
              end
            end else if (bit_cnt != 3'd7) begin
              bit_cnt  <= bit_cnt + 3'd1;
              shreg    <= {shreg[6:0], 1'b0};
              bus.mosi <= shreg[6];
            end else if (!last_byte) begin
              bit_cnt  <= '0;
              byte_cnt <= byte_cnt + 1'b1;
              shreg    <= bus.data_in;
              bus.mosi <= bus.data_in[7];
            end
          end
        end

        RX: begin
          if (tick) begin
            bus.sclk <= ~bus.sclk;
            if (!bus.sclk) begin
              shreg <= {shreg[6:0], bus.miso};
              if (bit_cnt == 3'd7) begin
                bus.data_out <= {shreg[6:0], bus.miso};
                bus.address  <= byte_cnt[AW-1:0];
                bus.wr       <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7 && !last_byte) byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase

      if (finish) begin
        state    <= IDLE;
        bus.cs_n <= 1'b1;
        bus.busy <= 1'b0;
        bus.done <= 1'b1;
        bus.sclk <= 1'b0;
        bus.mosi <= 1'b1;
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end
    end
  end
endmodule
